// File: rtl/dglk_spi_slave_pkg.sv
// dglk_spi_slave_pkg: frame-length helper, address-field packing constants and FSM states.
package dglk_spi_slave_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  localparam int ADR_W = 12;
  localparam int FLD8_W = 8;
  localparam int FLD16_MSB = 15;
  localparam int FLD16_LO_W = 11;
  function automatic int frame_len(input int adr_len, input int w_spi);
    return 8 + 8*adr_len + w_spi;
  endfunction
endpackage

// File: rtl/dglk_spi_sync_edge.sv
// dglk_spi_sync_edge: N_SYNC-stage synchroniser with registered-history rise/fall detect.
module dglk_spi_sync_edge #(
  parameter int N_SYNC = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [N_SYNC-1:0] sr;
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= {N_SYNC{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr <= {sr[N_SYNC-2:0], d};
      prev <= sr[N_SYNC-1];
    end
  assign rise = sr[N_SYNC-1] & ~prev;
  assign fall = ~sr[N_SYNC-1] & prev;
endmodule

// File: rtl/dglk_spi_slave.sv
// dglk_spi_slave: oversampled SPI responder; receives address+data frame, returns tx buffer on miso.
// Optional DGLK_SPIS_ECHO_EN: each accepted frame's data is copied into the tx buffer.
module dglk_spi_slave
  import dglk_spi_slave_pkg::*;
#(
  parameter int W_REG = 32,
  parameter int N_SDAT = 1,
  parameter int ADR_LEN = 0,
  parameter bit SPI_CPOL = 1'b0,
  parameter bit SPI_CPHA = 1'b0,
  parameter int N_SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic csb,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  input  logic [W_REG*N_SDAT-1:0] tx_dat,
  input  logic tx_ld,
  output logic [ADR_W-1:0] rx_adr,
  output logic [W_REG*N_SDAT-1:0] rx_dat,
  output logic rx_vld,
  output logic frm_err,
  output logic busy
);
  localparam int W_SPI = W_REG*N_SDAT;
  localparam int F = frame_len(ADR_LEN, W_SPI);
  localparam int W_CNT = $clog2(F+2);
  localparam logic [W_CNT-1:0] CNT_F = W_CNT'(F);
  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(F+1);
  logic csb_rise, csb_fall, sclk_rise, sclk_fall, lead, trail;
  logic smp, shf, start, ld_ok;
  logic [N_SYNC-1:0] mosi_sr;
  logic [W_CNT-1:0] cnt;
  logic [F-1:0] tx_sr, rx_sr;
  logic [W_SPI-1:0] tx_buf;
  logic [ADR_W-1:0] adr_nx;
  state_t state, state_nx;
  // csb history resets low so a frame cut by reset needs a fresh high-then-low
  dglk_spi_sync_edge #(.N_SYNC(N_SYNC), .RST_VAL(1'b0)) u_csb (
    .clk(clk), .rst_n(rst_n), .d(csb), .rise(csb_rise), .fall(csb_fall)
  );
  dglk_spi_sync_edge #(.N_SYNC(N_SYNC), .RST_VAL(SPI_CPOL)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );
  assign lead = SPI_CPOL ? sclk_fall : sclk_rise;
  assign trail = SPI_CPOL ? sclk_rise : sclk_fall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == ST_IDLE && csb_fall) ? ST_SHIFT :
               (state == ST_SHIFT && csb_rise) ? ST_DONE :
               (state == ST_DONE) ? ST_IDLE : state;
  // shift edges before the first sample are skipped so the preloaded MSB survives in CPHA=1
  always_comb begin
    busy = state != ST_IDLE;
    start = state == ST_IDLE && csb_fall;
    ld_ok = state == ST_IDLE && tx_ld && !csb_fall;
    smp = state == ST_SHIFT && (SPI_CPHA ? trail : lead);
    shf = state == ST_SHIFT && (SPI_CPHA ? lead : trail) && cnt != '0;
    miso = (state == ST_SHIFT && cnt <= CNT_F) ? tx_sr[F-1] : 1'b0;
  end
  if (ADR_LEN != 0) begin : g_adr16
    assign adr_nx = {rx_sr[W_SPI+FLD16_MSB], rx_sr[W_SPI +: FLD16_LO_W]};
  end else begin : g_adr8
    assign adr_nx = {{(ADR_W-FLD8_W){1'b0}}, rx_sr[W_SPI +: FLD8_W]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mosi_sr <= '0;
      cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      tx_buf <= '0;
      rx_adr <= '0;
      rx_dat <= '0;
      rx_vld <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      mosi_sr <= {mosi_sr[N_SYNC-2:0], mosi};
      rx_vld <= state == ST_DONE && cnt == CNT_F;
      frm_err <= state == ST_DONE && cnt != CNT_F;
      if (start) begin
        cnt <= '0;
        tx_sr <= {{(F-W_SPI){1'b0}}, tx_buf};
      end else if (shf) tx_sr <= {tx_sr[F-2:0], 1'b0};
      if (smp) begin
        rx_sr <= {rx_sr[F-2:0], mosi_sr[N_SYNC-1]};
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
      if (state == ST_DONE && cnt == CNT_F) begin
        rx_adr <= adr_nx;
        rx_dat <= rx_sr[W_SPI-1:0];
      end
      if (ld_ok) tx_buf <= tx_dat;
`ifdef DGLK_SPIS_ECHO_EN
      else if (rx_vld) tx_buf <= rx_dat;
`endif
    end
endmodule
